// File: rtl/sticky_right_shift.sv
// Pipelined logical right shifter with guard/round/sticky capture.
// One register stage per shift-count bit, stalled globally by the output handshake.
`timescale 1ns/1ps
module sticky_right_shift #(
  parameter int WIDTH = 64,
  localparam int SW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             guard,
  output logic             round,
  output logic             sticky
);

  localparam int MW = WIDTH + 2;

  logic                   w_advance;
  logic [SW-1:0][MW-1:0]  r_m;
  logic [SW-1:0][MW-1:0]  w_m_in;
  logic [SW-1:0][MW-1:0]  w_m_out;
  logic [SW-1:0]          r_s;
  logic [SW-1:0]          w_s_in;
  logic [SW-1:0]          w_s_out;
  logic [SW-1:0]          r_vld;
  logic [SW-1:0]          w_bit;

  // Shift by a fixed power of two; returns {m_next, s_next}. Oversized shifts fold everything into sticky.
  function automatic logic [MW:0] f_stage(input logic [MW-1:0] m, input logic s, input int sh);
    logic [MW-1:0] mask;
    logic [MW:0]   res;
    if (sh >= MW) begin
      res    = '0;
      res[0] = s | (|m);
    end else begin
      mask = ~({MW{1'b1}} << sh);
      res  = {m >> sh, s | (|(m & mask))};
    end
    return res;
  endfunction

  assign w_advance = out_ready | ~r_vld[SW-1];
  assign in_ready  = w_advance;
  assign out_valid = r_vld[SW-1];

  assign w_m_in[0] = {a, 2'b00};
  assign w_s_in[0] = 1'b0;
  assign w_bit[0]  = shift[0];

  for (genvar k = 0; k < SW; k++) begin : g_stage
    logic [MW:0] w_sh;

    if (k > 0) begin : g_link
      assign w_m_in[k] = r_m[k-1];
      assign w_s_in[k] = r_s[k-1];
    end

    assign w_sh       = f_stage(w_m_in[k], w_s_in[k], 2**k);
    assign w_m_out[k] = w_bit[k] ? w_sh[MW:1] : w_m_in[k];
    assign w_s_out[k] = w_bit[k] ? w_sh[0]    : w_s_in[k];

    // Count bit k is delayed k cycles so it meets its beat at stage k.
    if (k > 0) begin : g_cnt
      logic [k-1:0] r_dly;
      if (k == 1) begin : g_one
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)         r_dly <= '0;
          else if (w_advance) r_dly <= shift[k];
        end
      end else begin : g_many
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)         r_dly <= '0;
          else if (w_advance) r_dly <= {r_dly[k-2:0], shift[k]};
        end
      end
      assign w_bit[k] = r_dly[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m   <= '0;
      r_s   <= '0;
      r_vld <= '0;
    end else if (w_advance) begin
      r_m   <= w_m_out;
      r_s   <= w_s_out;
      r_vld <= {r_vld[SW-2:0], in_valid};
    end
  end

  assign y      = r_m[SW-1][MW-1:2];
  assign guard  = r_m[SW-1][1];
  assign round  = r_m[SW-1][0];
  assign sticky = r_s[SW-1];

endmodule

// File: tb/tb_sticky_right_shift.sv
// Randomized scoreboard bench for sticky_right_shift against a wide-arithmetic reference.
`timescale 1ns/1ps
module tb_sticky_right_shift;
  localparam int W  = 64;
  localparam int SW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [SW-1:0] shift = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  y;
  logic          guard, round, sticky;

  always #5 clk = ~clk;

  sticky_right_shift #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .guard(guard), .round(round), .sticky(sticky)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_out    = 0;
  int          base;
  bit          lat_on     = 1'b1;
  bit          prev_stall = 1'b0;
  logic [66:0] prev_out;
  logic [66:0] exp_q[$];
  int          acc_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Place a at the top of a 200-bit field and shift; everything below round is sticky.
  function automatic logic [66:0] model(input logic [63:0] av, input logic [6:0] sv);
    logic [199:0] w;
    w = {av, 136'b0} >> sv;
    return {w[199:136], w[135], w[134], |w[133:0]};
  endfunction

  task automatic cycle(input bit iv, input logic [63:0] av, input logic [6:0] sv, input bit ordy);
    logic [66:0] e;
    logic        exp_rdy;
    int          t;
    @(negedge clk);
    in_valid  = iv;
    a         = av;
    shift     = sv;
    out_ready = ordy;
    #1;
    cyc++;
    exp_rdy = out_ready | ~out_valid;
    chk("in_ready", in_ready, exp_rdy);
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {y, guard, round, sticky}, prev_out);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        chk("data", {y, guard, round, sticky}, e);
        if (lat_on) chk("latency", cyc - t, 7);
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, shift));
      acc_q.push_back(cyc);
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {y, guard, round, sticky};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {y, guard, round, sticky}, 0);
    chk("rst_in_ready", in_ready, 1);
    exp_q.delete();
    acc_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, '0, '0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [63:0] rand_a();
    return {$urandom(), $urandom()} >> $urandom_range(0, 63);
  endfunction

  initial begin
    do_reset();

    repeat (20) begin
      cycle(1'b0, rand_a(), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
      chk("idle_valid", out_valid, 0);
    end

    cycle(1'b1, 64'h8000_0000_0000_0003, 7'd2,   1'b1);
    cycle(1'b1, 64'h0000_0000_0000_00FF, 7'd5,   1'b1);
    cycle(1'b1, 64'h0000_0000_0000_00FF, 7'd66,  1'b1);
    cycle(1'b1, 64'h0,                   7'd127, 1'b1);
    cycle(1'b1, 64'hDEAD_BEEF_0123_4567, 7'd0,   1'b1);
    cycle(1'b1, 64'h0000_0000_0000_0001, 7'd127, 1'b1);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64,  1'b1);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd65,  1'b1);
    cycle(1'b1, 64'h4000_0000_0000_0000, 7'd63,  1'b1);
    drain(10);

    base = n_out;
    for (int i = 0; i < 100; i++)
      cycle(1'b1, rand_a(), 7'($urandom_range(0, 127)), 1'b1);
    drain(10);
    chk("stream_count", n_out - base, 100);

    lat_on = 1'b0;
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), rand_a(), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    drain(20);
    lat_on = 1'b1;

    for (int i = 0; i < 4; i++)
      cycle(1'b1, rand_a(), 7'($urandom_range(0, 127)), 1'b1);
    do_reset();
    repeat (10) begin
      cycle(1'b0, '0, '0, 1'b1);
      chk("post_rst_valid", out_valid, 0);
    end
    base = n_out;
    cycle(1'b1, 64'h0123_4567_89AB_CDEF, 7'd9, 1'b1);
    drain(10);
    chk("post_rst_count", n_out - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sticky_right_shift.md
# sticky_right_shift

Pipelined right-shifter with guard/round/sticky capture, the denormalizing counterpart to the leading-zero-count normalize path. Aligns a WIDTH-bit mantissa right by a shift count in the same width as the LZC count field, so exponent alignment and denormal generation use the same count format. Sits in the precision datapath between exponent-difference logic and the adder/rounder. It has a valid/ready handshake on both sides and one pipeline stage per shift-count bit.

## Interface
- WIDTH, 64, mantissa width in bits; power of two, ≥ 4
- SW (localparam), $clog2(WIDTH)+1, shift-count width; L = SW is the pipeline depth
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept an input beat this cycle
- a  input  WIDTH  mantissa to shift
- shift  input  SW  right-shift amount, 0 to 2^SW-1
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the output beat
- y  output  WIDTH  shifted mantissa
- guard  output  1  first bit shifted out below y[0]
- round  output  1  second bit shifted out
- sticky  output  1  OR of all bits shifted out below round

## Operation
- Internal datapath per stage: {m[WIDTH+1:0], s}. m holds the mantissa plus guard and round bits; s is sticky.
- Input is accepted when in_valid && in_ready. Stage 0 loads m = {a, 2'b00}, s = 0, the shift count, and valid = 1.
- Stage k, for k = 0..SW-1, applies a shift of 2^k when count bit k = 1:
  - m_next = m >> 2^k
  - s_next = s | (OR of the 2^k low bits of m that are shifted out)
- When 2^k ≥ WIDTH+2, the stage clears m and sets s |= |m.
- When bit k = 0, m and s pass through unchanged.
- Each stage registers its result, the remaining count bits, and a valid flag.
- Final stage outputs:
  - y = m[WIDTH+1:2]
  - guard = m[1]
  - round = m[0]
  - sticky = s
- Arithmetic is pure logical shift; there is no sign extension.
- If shift ≥ WIDTH+2, then y = 0, guard = round = 0, and sticky = |a.
- If shift = 0, then y = a and guard = round = sticky = 0.
- If a = 0, all outputs are 0 for any shift.
- Flow control is a global stall:
  - advance = out_ready | ~out_valid
  - All stages shift forward only when advance = 1.
  - in_ready = advance, a combinational function of out_ready and the final valid flag.
- Bubbles (valid = 0) propagate through the pipeline but do not collapse; throughput is 1 beat/cycle when out_ready is held high.
- While out_valid && !out_ready:
  - All stage registers hold.
  - y, guard, round and sticky remain stable.
  - in_ready = 0.
- Beats leave in the order they were accepted; no beat is dropped or duplicated.

## Timing
- Reset (rst_n low, async assert) clears:
  - all stage valid flags
  - all data registers
  - out_valid = 0, y = 0, guard = round = sticky = 0
  - in_ready = 1 immediately, since out_valid = 0
- Reset deassertion must be synchronous to clk at the system level. The first accept is possible on the first clk edge with rst_n high.
- Latency is L cycles: a beat accepted at edge n appears with out_valid = 1 after edge n+L-1 (it is visible during cycle n+L-1), assuming no stall.
- A stall of S cycles adds S cycles to every beat in flight.
- Reset asserted mid-operation discards all beats in flight. No partial output appears after reset.
- If in_valid = 1 and in_ready = 0, the beat is not accepted. The source must hold a and shift until in_ready = 1.
- out_valid may assert in the same cycle out_ready toggles. Handoff occurs only on an edge where both are 1.

## Test plan
- Reset and idle: with rst_n low, all outputs are 0 and in_ready = 1. After release with no input, out_valid stays 0 for 20 cycles.
- Basic shift, WIDTH=64, out_ready=1: a=64'h8000_0000_0000_0003, shift=2. After 7 cycles, y=64'h2000_0000_0000_0000, guard=1, round=1, sticky=0.
- Sticky and saturation: a=64'h0000_0000_0000_00FF, shift=5 gives y=7, guard=1, round=1, sticky=1. Then shift=66 gives y=0, guard=round=0, sticky=1. Then a=0, shift=127 gives all zeros.
- Back-to-back streaming: 100 random {a, shift} beats on consecutive cycles with out_ready=1. Outputs match the reference model in order at 1 beat/cycle, with the first output at cycle 7.
- Backpressure: random in_valid and random out_ready at 50% each for 1000 cycles. No loss, duplication or reorder. Outputs stay stable while out_valid && !out_ready, and in_ready == (out_ready | ~out_valid) every cycle.
- Mid-flight reset: accept 4 beats, then assert rst_n low for 1 cycle. out_valid stays 0 until new beats are accepted, and the first new beat appears exactly 7 cycles after its accept.
